// File: rtl/rc4_xor_stream_ctrl.sv
// RC4 stream controller: requests state-array and keystream bytes, XORs them with ciphertext into plaintext.
// Latency: start->gen_state_arr_o 1 cycle, val_ready_i->cready_o 1 cycle, ciphertext accept->pvalid_o 1 cycle.
// Backpressure: plaintext is held in OUT_HOLD until pready_i; ciphertext only accepted in CT_WAIT; generator waits time out.
module rc4_xor_stream_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LEN_W          = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start_i,
  input  logic [31:0]      key_i,
  input  logic [LEN_W-1:0] msg_len_i,
  output logic [31:0]      rc4_key_o,
  output logic             gen_state_arr_o,
  input  logic             sarr_generated_i,
  output logic             gen_val_o,
  input  logic             val_ready_i,
  input  logic [7:0]       keystream_i,
  input  logic [7:0]       cdata_i,
  input  logic             cvalid_i,
  output logic             cready_o,
  output logic [7:0]       pdata_o,
  output logic             pvalid_o,
  output logic             plast_o,
  input  logic             pready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  // Timer must be able to hold TIMEOUT_CYCLES itself so it can saturate there.
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_REQ,
    ST_INIT_WAIT,
    ST_KS_REQ,
    ST_KS_WAIT,
    ST_CT_WAIT,
    ST_OUT_HOLD,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [TMR_W-1:0] tmr_inc;
  logic             tmr_expire;
  logic [LEN_W-1:0] remaining_q;
  logic [7:0]       ks_q;

  // Control strobes from the FSM to the datapath registers.
  logic start_acc;
  logic ks_load;
  logic ct_acc;
  logic out_acc;

  assign tmr_inc    = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + TMR_W'(1);
  assign tmr_expire = (tmr_inc == TMR_MAX);

  // State and wait-timer registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next-state decode, generator strobes, stream handshakes and status flags.
  always_comb begin
    state_d         = state_q;
    tmr_d           = tmr_q;
    start_acc       = 1'b0;
    ks_load         = 1'b0;
    ct_acc          = 1'b0;
    out_acc         = 1'b0;
    gen_state_arr_o = 1'b0;
    gen_val_o       = 1'b0;
    cready_o        = 1'b0;
    done_o          = 1'b0;
    busy_o          = 1'b1;
    err_o           = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        busy_o = 1'b0;
        err_o  = (state_q == ST_ERROR);
        if (start_i) begin
          start_acc = 1'b1;
          // A zero-length message never touches the generator.
          state_d   = (msg_len_i == '0) ? ST_DONE : ST_INIT_REQ;
        end
      end
      ST_INIT_REQ: begin
        gen_state_arr_o = 1'b1;
        tmr_d           = '0;
        state_d         = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (sarr_generated_i) begin
          state_d = ST_KS_REQ;
        end else begin
          tmr_d = tmr_inc;
          if (tmr_expire) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_KS_REQ: begin
        // val_ready_i is deliberately not looked at here.
        gen_val_o = 1'b1;
        tmr_d     = '0;
        state_d   = ST_KS_WAIT;
      end
      ST_KS_WAIT: begin
        if (val_ready_i) begin
          ks_load = 1'b1;
          state_d = ST_CT_WAIT;
        end else begin
          tmr_d = tmr_inc;
          if (tmr_expire) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_CT_WAIT: begin
        cready_o = 1'b1;
        if (cvalid_i) begin
          ct_acc  = 1'b1;
          state_d = ST_OUT_HOLD;
        end
      end
      ST_OUT_HOLD: begin
        if (pready_i) begin
          out_acc = 1'b1;
          state_d = (remaining_q != '0) ? ST_KS_REQ : ST_DONE;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Key/length latch, keystream byte, and the registered plaintext output stage.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rc4_key_o   <= '0;
      remaining_q <= '0;
      ks_q        <= '0;
      pdata_o     <= '0;
      pvalid_o    <= 1'b0;
      plast_o     <= 1'b0;
    end else begin
      if (start_acc) begin
        rc4_key_o   <= key_i;
        remaining_q <= msg_len_i;
      end
      if (ks_load) begin
        ks_q <= keystream_i;
      end
      if (ct_acc) begin
        pdata_o  <= cdata_i ^ ks_q;
        pvalid_o <= 1'b1;
        plast_o  <= (remaining_q == LEN_W'(1));
        if (remaining_q != '0) begin
          remaining_q <= remaining_q - LEN_W'(1);
        end
      end
      if (out_acc) begin
        pvalid_o <= 1'b0;
        plast_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rc4_xor_stream_ctrl.sv
`timescale 1ns/1ps
module tb_rc4_xor_stream_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] key_i = '0;
  logic [15:0] msg_len_i = '0;
  logic [31:0] rc4_key_o;
  logic        gen_state_arr_o;
  logic        sarr_generated_i = 1'b0;
  logic        gen_val_o;
  logic        val_ready_i = 1'b0;
  logic [7:0]  keystream_i = '0;
  logic [7:0]  cdata_i = '0;
  logic        cvalid_i = 1'b0;
  logic        cready_o;
  logic [7:0]  pdata_o;
  logic        pvalid_o;
  logic        plast_o;
  logic        pready_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  always #5 clk = ~clk;

  rc4_xor_stream_ctrl #(.TIMEOUT_CYCLES(TMO), .LEN_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .start_i(start_i), .key_i(key_i), .msg_len_i(msg_len_i),
    .rc4_key_o(rc4_key_o), .gen_state_arr_o(gen_state_arr_o), .sarr_generated_i(sarr_generated_i),
    .gen_val_o(gen_val_o), .val_ready_i(val_ready_i), .keystream_i(keystream_i),
    .cdata_i(cdata_i), .cvalid_i(cvalid_i), .cready_o(cready_o),
    .pdata_o(pdata_o), .pvalid_o(pvalid_o), .plast_o(plast_o), .pready_i(pready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected plaintext is ciphertext XOR keystream, last flag on the final byte.
  typedef struct packed { logic [7:0] dat; logic last; } exp_t;
  logic [7:0] ks_q[$];
  logic [7:0] ct_q[$];
  exp_t       exp_q[$];
  logic [7:0] got_q[$];

  bit   sarr_en = 1'b1;
  int   sarr_delay = 5;
  int   sarr_tmr = 0;
  int   ks_tmr = 0;
  bit   ct_pop = 1'b0;
  int   stall_idx = -1;
  int   stall_left = 0;
  int   out_idx = 0;
  bit   prev_hold = 1'b0;
  logic [7:0] prev_pd = '0;
  logic prev_pl = 1'b0;
  int   n_sarr = 0, n_val = 0, n_done = 0, n_stall = 0;
  exp_t e;
  logic [7:0] tmp8;

  task automatic add_byte(input logic [7:0] ks, input logic [7:0] ct, input logic last);
    exp_t x;
    ks_q.push_back(ks);
    ct_q.push_back(ct);
    x.dat = ct ^ ks;
    x.last = last;
    exp_q.push_back(x);
  endtask

  // Generator/source/sink environment and the per-cycle output compare.
  always @(negedge clk) begin
    if (!n_rst) begin
      prev_hold = 1'b0;
      sarr_generated_i = 1'b0;
      val_ready_i = 1'b0;
      sarr_tmr = 0;
      ks_tmr = 0;
      ct_pop = 1'b0;
      pready_i = 1'b1;
    end else begin
      sarr_generated_i = 1'b0;
      if (sarr_tmr > 0) begin
        if (sarr_tmr == 1) sarr_generated_i = 1'b1;
        sarr_tmr--;
      end
      if (gen_state_arr_o) begin
        n_sarr++;
        if (sarr_en) sarr_tmr = sarr_delay;
      end

      val_ready_i = 1'b0;
      keystream_i = 8'h00;
      if (ks_tmr == 1) begin
        val_ready_i = 1'b1;
        if (ks_q.size() > 0) keystream_i = ks_q.pop_front();
      end
      ks_tmr = 0;
      if (gen_val_o) begin
        // Decoy response in the request cycle itself; it must be ignored.
        n_val++;
        val_ready_i = 1'b1;
        keystream_i = 8'hC3;
        ks_tmr = 1;
      end

      if (ct_pop) begin
        if (ct_q.size() > 0) tmp8 = ct_q.pop_front();
        ct_pop = 1'b0;
      end
      cvalid_i = (ct_q.size() > 0);
      cdata_i  = cvalid_i ? ct_q[0] : 8'h00;
      if (cready_o && cvalid_i) ct_pop = 1'b1;

      if (prev_hold) begin
        check("hold_pvalid", {31'd0, pvalid_o}, 32'd1);
        check("hold_pdata", {24'd0, pdata_o}, {24'd0, prev_pd});
        check("hold_plast", {31'd0, plast_o}, {31'd0, prev_pl});
      end
      check("plast_without_pvalid", {31'd0, plast_o & ~pvalid_o}, 32'd0);

      pready_i = 1'b1;
      if (pvalid_o && out_idx == stall_idx && stall_left > 0) begin
        pready_i = 1'b0;
        stall_left--;
        n_stall++;
      end
      if (pvalid_o && pready_i) begin
        check("byte_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pdata", {24'd0, pdata_o}, {24'd0, e.dat});
          check("plast", {31'd0, plast_o}, {31'd0, e.last});
        end
        got_q.push_back(pdata_o);
        out_idx++;
      end
      prev_hold = pvalid_o && !pready_i;
      prev_pd   = pdata_o;
      prev_pl   = plast_o;

      if (done_o) begin
        n_done++;
        check("done_after_last_byte", exp_q.size(), 32'd0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_sarr = 0; n_val = 0; n_done = 0; n_stall = 0; out_idx = 0;
    got_q.delete();
  endtask

  task automatic pulse_start(input logic [31:0] k, input logic [15:0] l);
    key_i = k; msg_len_i = l; start_i = 1'b1;
    tick();
    start_i = 1'b0; key_i = '0; msg_len_i = '0;
  endtask

  // Runs one message to completion; optionally pulses a stray start while busy.
  task automatic run_msg(input logic [31:0] k, input logic [15:0] l, input int inject_at);
    int cyc;
    clear_counts();
    pulse_start(k, l);
    check("start_to_gen_state_arr", {31'd0, gen_state_arr_o}, 32'd1);
    check("busy_after_start", {31'd0, busy_o}, 32'd1);
    check("err_clear_on_start", {31'd0, err_o}, 32'd0);
    cyc = 0;
    while (n_done == 0 && !err_o && cyc < 400) begin
      if (cyc == inject_at) begin
        key_i = 32'hDEADBEEF; msg_len_i = 16'd7; start_i = 1'b1;
      end
      tick();
      start_i = 1'b0; key_i = '0; msg_len_i = '0;
      cyc++;
    end
    tick();
    tick();
    check("done_single_pulse", n_done, 32'd1);
    check("idle_after_done", {31'd0, busy_o}, 32'd0);
  endtask

  int cyc;

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_rc4_key", rc4_key_o, 32'd0);
    check("rst_pdata", {24'd0, pdata_o}, 32'd0);
    check("rst_pvalid", {31'd0, pvalid_o}, 32'd0);
    check("rst_plast", {31'd0, plast_o}, 32'd0);
    check("rst_gen_state_arr", {31'd0, gen_state_arr_o}, 32'd0);
    check("rst_gen_val", {31'd0, gen_val_o}, 32'd0);
    check("rst_cready", {31'd0, cready_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    n_rst = 1'b1;
    tick();

    // Basic 3-byte message
    add_byte(8'hAA, 8'h11, 1'b0);
    add_byte(8'h55, 8'h22, 1'b0);
    add_byte(8'h0F, 8'h33, 1'b1);
    run_msg(32'h01020304, 16'd3, -1);
    check("t1_key", rc4_key_o, 32'h01020304);
    check("t1_sarr_pulses", n_sarr, 32'd1);
    check("t1_val_pulses", n_val, 32'd3);
    check("t1_nbytes", got_q.size(), 32'd3);
    check("t1_b0", {24'd0, got_q[0]}, 32'hBB);
    check("t1_b1", {24'd0, got_q[1]}, 32'h77);
    check("t1_b2", {24'd0, got_q[2]}, 32'h3C);

    // Same message with a 10-cycle downstream stall on byte 2
    add_byte(8'hAA, 8'h11, 1'b0);
    add_byte(8'h55, 8'h22, 1'b0);
    add_byte(8'h0F, 8'h33, 1'b1);
    stall_idx = 1; stall_left = 10;
    run_msg(32'h01020304, 16'd3, -1);
    stall_idx = -1;
    check("t2_stall_cycles", n_stall, 32'd10);
    check("t2_val_pulses", n_val, 32'd3);
    check("t2_b1", {24'd0, got_q[1]}, 32'h77);
    check("t2_b2", {24'd0, got_q[2]}, 32'h3C);

    // Zero-length message
    clear_counts();
    pulse_start(32'h0BADF00D, 16'd0);
    tick();
    check("t3_done", n_done, 32'd1);
    check("t3_sarr_pulses", n_sarr, 32'd0);
    check("t3_val_pulses", n_val, 32'd0);
    check("t3_busy_low", {31'd0, busy_o}, 32'd0);
    check("t3_key", rc4_key_o, 32'h0BADF00D);

    // Generator never reports the state array: timeout after 16 wait cycles
    sarr_en = 1'b0;
    add_byte(8'hFF, 8'h00, 1'b1);
    clear_counts();
    pulse_start(32'hCAFEF00D, 16'd1);
    cyc = 1;
    while (!err_o && cyc < 100) begin
      tick();
      cyc++;
    end
    check("t4_err_cycle", cyc, 32'd18);
    check("t4_err", {31'd0, err_o}, 32'd1);
    check("t4_busy", {31'd0, busy_o}, 32'd0);
    check("t4_gen_val", {31'd0, gen_val_o}, 32'd0);
    check("t4_val_pulses", n_val, 32'd0);
    tick();
    check("t4_err_sticky", {31'd0, err_o}, 32'd1);
    sarr_en = 1'b1;
    run_msg(32'h00000042, 16'd1, -1);
    check("t4_recover_b0", {24'd0, got_q[0]}, 32'hFF);
    check("t4_recover_err", {31'd0, err_o}, 32'd0);

    // Stray start while busy is ignored
    add_byte(8'hAA, 8'h11, 1'b0);
    add_byte(8'h55, 8'h22, 1'b0);
    add_byte(8'h0F, 8'h33, 1'b1);
    run_msg(32'h01020304, 16'd3, 8);
    check("t5_key", rc4_key_o, 32'h01020304);
    check("t5_sarr_pulses", n_sarr, 32'd1);
    check("t5_nbytes", got_q.size(), 32'd3);

    // Reset while holding an output byte
    add_byte(8'hAA, 8'h11, 1'b0);
    add_byte(8'h55, 8'h22, 1'b0);
    add_byte(8'h0F, 8'h33, 1'b1);
    stall_idx = 0; stall_left = 50;
    clear_counts();
    pulse_start(32'h01020304, 16'd3);
    cyc = 0;
    while (!pvalid_o && cyc < 100) begin
      tick();
      cyc++;
    end
    check("t6_reached_out_hold", {31'd0, pvalid_o}, 32'd1);
    tick();
    n_rst = 1'b0;
    #1;
    check("t6_rst_pvalid", {31'd0, pvalid_o}, 32'd0);
    check("t6_rst_pdata", {24'd0, pdata_o}, 32'd0);
    check("t6_rst_plast", {31'd0, plast_o}, 32'd0);
    check("t6_rst_key", rc4_key_o, 32'd0);
    check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
    check("t6_rst_cready", {31'd0, cready_o}, 32'd0);
    check("t6_rst_gen_val", {31'd0, gen_val_o}, 32'd0);
    ks_q.delete(); ct_q.delete(); exp_q.delete();
    stall_idx = -1; stall_left = 0;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    check("t6_no_done_after_rst", n_done, 32'd0);
    add_byte(8'hAA, 8'h11, 1'b0);
    add_byte(8'h55, 8'h22, 1'b0);
    add_byte(8'h0F, 8'h33, 1'b1);
    run_msg(32'h01020304, 16'd3, -1);
    check("t6_sarr_pulses", n_sarr, 32'd1);
    check("t6_b0", {24'd0, got_q[0]}, 32'hBB);
    check("t6_b2", {24'd0, got_q[2]}, 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
